// File: rtl/fp_pkg.sv
// Shared constants and FSM state type for the single-precision normaliser.
package fp_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MANT_W  = 24;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StHold
    } state_e;

endpackage

// File: rtl/fp_exp_step.sv
// Saturating exponent increment/decrement with max/min detection.
module fp_exp_step
    import fp_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] exp_cur,
    output logic [W-1:0] exp_inc,
    output logic [W-1:0] exp_dec,
    output logic         at_max,
    output logic         at_min,
    output logic         inc_at_max
);

    // Increment holds at EXP_MAX; decrement holds at 1 (or at 0 if already there).
    assign at_max     = (exp_cur == W'(EXP_MAX));
    assign at_min     = (exp_cur <= W'(1));
    assign exp_inc    = at_max ? exp_cur : exp_cur + W'(1);
    assign exp_dec    = at_min ? exp_cur : exp_cur - W'(1);
    assign inc_at_max = (exp_inc == W'(EXP_MAX));

endmodule

// File: rtl/fp_normalizer.sv
// Iterative post-add normaliser: one shift per cycle, result held until consumed.
module fp_normalizer
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W:0]   in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [2:0]        out_flags
);

    localparam int unsigned FRAC_W = MANT_W - 1;

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [MANT_W:0]    mant_q, mant_d;
    logic [31:0]        result_q, result_d;
    logic [2:0]         flags_q, flags_d;

    logic [EXP_W-1:0]   exp_inc, exp_dec;
    logic               at_max, at_min, inc_at_max;

    fp_exp_step #(
        .W (EXP_W)
    ) u_exp_step (
        .exp_cur    (exp_q),
        .exp_inc    (exp_inc),
        .exp_dec    (exp_dec),
        .at_max     (at_max),
        .at_min     (at_min),
        .inc_at_max (inc_at_max)
    );

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = in_exp;
                    mant_d  = in_mant;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                // Rule order matters: overflow and zero outrank any shifting.
                if (at_max) begin
                    result_d = 32'({sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}});
                    flags_d  = 3'b100;
                    state_d  = StHold;
                end else if (mant_q == '0) begin
                    result_d = '0;
                    flags_d  = 3'b001;
                    state_d  = StHold;
                end else if (mant_q[MANT_W]) begin
                    mant_d  = mant_q >> 1;
                    exp_d   = exp_inc;
                    state_d = StHold;
                    if (inc_at_max) begin
                        result_d = 32'({sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}});
                        flags_d  = 3'b100;
                    end else begin
                        result_d = 32'({sign_q, exp_inc, mant_q[MANT_W-1:1]});
                        flags_d  = 3'b000;
                    end
                end else if (mant_q[MANT_W-1]) begin
                    result_d = 32'({sign_q, exp_q, mant_q[FRAC_W-1:0]});
                    flags_d  = 3'b000;
                    state_d  = StHold;
                end else if (at_min) begin
                    result_d = 32'({sign_q, {EXP_W{1'b0}}, {FRAC_W{1'b0}}});
                    flags_d  = 3'b010;
                    state_d  = StHold;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_dec;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StHold);
    assign out_result = result_q;
    assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer: expected results queued at acceptance, checked on output.
module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'h00;
    logic [24:0] in_mant = 25'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    fp_normalizer #(
        .EXP_W  (8),
        .MANT_W (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc++;

    // Reference model: leading-one count instead of step-by-step iteration.
    function automatic exp_t model(input logic s, input logic [7:0] e, input logic [24:0] m);
        exp_t        x;
        int          msb;
        int          lz;
        int          maxsh;
        logic [24:0] sh;
        x.f = 3'b000;
        x.acc = 0;
        x.lat = 1;
        if (e == 8'hFF) begin
            x.r = {s, 8'hFF, 23'h0};
            x.f = 3'b100;
        end else if (m == 25'h0) begin
            x.r = 32'h0;
            x.f = 3'b001;
        end else if (m[24]) begin
            if (e == 8'hFE) begin
                x.r = {s, 8'hFF, 23'h0};
                x.f = 3'b100;
            end else begin
                x.r = {s, e + 8'd1, m[23:1]};
            end
        end else begin
            msb = 0;
            for (int i = 0; i < 24; i++) if (m[i]) msb = i;
            lz = 23 - msb;
            maxsh = (e >= 8'd1) ? int'(e) - 1 : 0;
            if (lz <= maxsh) begin
                sh = m << lz;
                x.r = {s, 8'(int'(e) - lz), sh[22:0]};
                x.lat = 1 + lz;
            end else begin
                x.r = {s, 31'h0};
                x.f = 3'b010;
                x.lat = 1 + maxsh;
            end
        end
        return x;
    endfunction

    // Output side of the scoreboard: compare on every rising edge of out_valid.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL spurious_output: result=%h flags=%b with nothing pending",
                             out_result, out_flags);
                end else begin
                    e = sb.pop_front();
                    n_total++;
                    if (out_result !== e.r)
                        $display("FAIL result: got %h want %h", out_result, e.r);
                    else
                        n_pass++;
                    n_total++;
                    if (out_flags !== e.f)
                        $display("FAIL flags: got %b want %b", out_flags, e.f);
                    else
                        n_pass++;
                    n_total++;
                    if (cyc - e.acc !== e.lat)
                        $display("FAIL latency: got %0d want %0d", cyc - e.acc, e.lat);
                    else
                        n_pass++;
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m, input bit hold);
        exp_t x;
        int   n;
        in_sign = s;
        in_exp = e;
        in_mant = m;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL send_timeout: in_ready got %b want 1", in_ready);
        end
        x = model(s, e, m);
        x.acc = cyc + 1;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            n_total++;
            $display("FAIL out_timeout: out_valid got %b want 1", out_valid);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        n_total++;
        if (out_result !== 32'h0) $display("FAIL reset_result: got %h want 0", out_result);
        else n_pass++;
        n_total++;
        if (out_flags !== 3'b000) $display("FAIL reset_flags: got %b want 000", out_flags);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        send(1'b0, 8'h80, 25'h0800000, 1'b0);
        wait_out();
        release_out();
        send(1'b0, 8'h7F, 25'h1800000, 1'b0);
        wait_out();
        release_out();
        send(1'b0, 8'h7F, 25'h0000001, 1'b0);
        wait_out();
        release_out();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL basic_release: valid/ready got %b%b want 01", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_zero_overflow();
        send(1'b1, 8'h85, 25'h0, 1'b0);
        wait_out();
        release_out();
        send(1'b0, 8'hFE, 25'h1000000, 1'b0);
        wait_out();
        release_out();
    endtask

    task automatic test_underflow_hold();
        send(1'b0, 8'h03, 25'h0000100, 1'b0);
        wait_out();
        // A new operand offered during HOLD must be ignored.
        in_valid = 1'b1;
        in_exp = 8'h80;
        in_mant = 25'h0800000;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL hold_handshake: valid/ready got %b%b want 10", out_valid, in_ready);
            else n_pass++;
            n_total++;
            if (out_result !== 32'h0 || out_flags !== 3'b010)
                $display("FAIL hold_stable: got %h/%b want 00000000/010", out_result, out_flags);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        release_out();
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        send(1'b0, 8'h7F, 25'h0000001, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL midreset_state: valid/ready got %b%b want 01", out_valid, in_ready);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL midreset_no_output: got %b want 0", out_valid);
        else n_pass++;
        send(1'b0, 8'h80, 25'h0800000, 1'b0);
        wait_out();
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  e;
        logic [24:0] m;
        int          n;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            unique case (i % 4)
                0: e = 8'hFF;
                1: e = 8'($urandom_range(0, 3));
                2: e = 8'hFE;
                default: e = 8'($urandom_range(0, 255));
            endcase
            m = 25'($urandom) & ((25'd1 << $urandom_range(0, 25)) - 25'd1);
            send(1'($urandom), e, m, 1'b1);
            n_total++;
            if (in_ready !== 1'b0) $display("FAIL b2b_busy: in_ready got %b want 0", in_ready);
            else n_pass++;
        end
        in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_total++;
        if (sb.size() !== 0) $display("FAIL b2b_drain: pending got %0d want 0", sb.size());
        else n_pass++;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_overflow();
        test_underflow_hold();
        test_reset_midflight();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning biased exponent width.
REQ-002 SHALL have parameter MANT_W, default 24, meaning significand width including hidden bit.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand present.
REQ-006 SHALL have port in_ready  output  1  block accepts operand.
REQ-007 SHALL have port in_sign  input  1  result sign.
REQ-008 SHALL have port in_exp  input  EXP_W  larger aligned exponent, biased by 127.
REQ-009 SHALL have port in_mant  input  MANT_W+1  raw significand sum; bit 24 is carry, bit 23 is hidden-bit position.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_result  output  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}.
REQ-013 SHALL have port out_flags  output  3  {overflow, underflow, zero}.

Function
REQ-014 SHALL implement FSM states IDLE, NORM, HOLD.
REQ-015 IDLE: in_ready=1; on in_valid at edge T, SHALL register sign/exp/mant and enter NORM.
REQ-016 NORM, each edge, first matching rule SHALL apply.
  - reg exp == 255: result {sign,255,0}, overflow=1, go HOLD.
  - mant == 0: result 0x00000000, zero=1, go HOLD.
  - mant[24]=1: mant >> 1 (truncate), exp+1; if new exp == 255 then {sign,255,0}, overflow=1; go HOLD.
  - mant[23]=1: go HOLD.
  - exp <= 1: flush to {sign,0,0}, underflow=1, go HOLD.
  - else: mant << 1, exp-1, stay NORM.
REQ-017 Latency SHALL be: out_valid high after edge T+1+N, N = left shifts performed (0..23).
REQ-018 Normal result SHALL be {sign, exp, mant[22:0]}; flags all 0.
REQ-019 HOLD: out_valid=1, out_result/out_flags stable; on out_ready SHALL return to IDLE at that edge.
REQ-020 in_ready SHALL be 0 in NORM and HOLD; at most one operand in flight.
REQ-021 out_valid SHALL never drop without out_ready handshake (except reset).
REQ-022 Exponent arithmetic SHALL be 8-bit unsigned; increment never wraps past 255, decrement never below 1.
REQ-023 in_valid in NORM/HOLD SHALL be ignored; upstream holds its operand.

Reset
REQ-024 rst high SHALL immediately force IDLE, out_valid=0, in_ready=1 after release, out_result=0, out_flags=0, internal regs 0.
REQ-025 rst during NORM or HOLD SHALL discard the in-flight operand; no result emitted.
REQ-026 First acceptance after reset SHALL be at the first rising edge with rst low and in_valid high.

Structure
REQ-027 fp_pkg SHALL hold EXP_W, MANT_W, BIAS=127, EXP_MAX=255, and the FSM state enum.
REQ-028 Sub-module fp_exp_step SHALL perform 8-bit exponent +1/-1 with at-max/at-min detect; normalizer instantiates one.

Verification
REQ-029 in_mant=0x0800000, in_exp=0x80, sign 0 -> out_result 0x40000000, flags 0, out_valid at T+1.
REQ-030 in_mant=0x1800000, in_exp=0x7F -> 0x40400000 (3.0), flags 0, at T+1.
REQ-031 in_mant=0x0000001, in_exp=0x7F -> 0x34000000, out_valid at T+24.
REQ-032 in_mant=0, in_exp=0x85, sign 1 -> 0x00000000, zero=1; then in_mant=0x1000000, in_exp=0xFE -> 0x7F800000, overflow=1.
REQ-033 in_mant=0x0000100, in_exp=0x03 -> {0,0,0}, underflow=1 at T+3; hold out_ready=0 for 5 cycles -> result stable, in_ready=0.
REQ-034 Assert rst at T+5 of the REQ-031 stimulus -> out_valid never rises, state IDLE, next operand processed normally.
